superscalar_dispatch_unit: RTL and testbench
============================================

// Module: superscalar_dispatch_unit
// PURPOSE
// - In-order, single-issue RV32IM dispatcher (Tomasulo style), between the instruction fetch queue (IFQ) and the int/mult/div/mem issue queues.
// - Decodes one instruction per cycle, reads operands or tags, allocates a result tag and routes the op to one queue.
// - Resolves branches/jumps itself; tracks results returned on the CDB.
// PARAMETERS
// - TAG_W, 6, tag width: 64 tags
// - XLEN, 32, data/PC width
// PORTS
// - clk                in   1     clock
// - rst                in   1     reset; one clock; synchronous, active-high
// - ifq_icode          in   32    instruction at IFQ head
// - ifq_pc             in   32    PC of ifq_icode
// - ifq_empty          in   1     IFQ has no valid instruction
// - dispatch_rd        out  1     head consumed this cycle (IFQ pops)
// - jump_branch_add    out  32    redirect target
// - jump_branch_valid  out  1     redirect fetch (flush IFQ)
// - cdb                cdb_bus    in: cdb_valid, cdb_tag[5:0], cdb_data[31:0]
// - queue_bus          queue_cmn_bus
//     - out: rs1_data/rs2_data[31:0], rs1_tag/rs2_tag[5:0], rs1_valid/rs2_valid, rd_tag[5:0], imm[31:0], funct3[2:0]
//     - in: int_full, mult_full, div_full, mem_full
// - int_queue_en       out  1     write int queue
// - disp_imm           out  1     operand 2 is queue_bus.imm, not rs2
// - disp_pc            out  32    = ifq_pc
// - opcode             out  7     = icode[6:0]
// - funct7             out  7     = icode[31:25]
// - mult_queue_en      out  1     write mult queue
// - div_queue_en       out  1     write div queue
// - mem_queue_en       out  1     write mem queue
// BEHAVIOUR
// - State:
//     - RF 32x32, x0 reads 0.
//     - RST 32 x {pending, tag}.
//     - Free-tag FIFO, 64 deep.
// - Reset: RF all 0; RST all not pending; FIFO full with tags 0..63 (pops 0 first).
// - All outputs are combinational. They are 0 while rst or ifq_empty.
// - Decode/routing (one *_queue_en max per cycle; en implies dispatch_rd):
//     - OP (0110011), funct7=0000001: funct3[2]=0 -> mult, else -> div. Other funct7 -> int.
//     - OP-IMM (0010011), LUI, AUIPC -> int, disp_imm=1. imm is the sign-extended I- or U-immediate.
//     - LOAD -> mem with I-imm. STORE -> mem with S-imm, no rd tag allocated.
//     - BRANCH, JAL, JALR: handled internally, no queue_en.
//     - Any other opcode: NOP, dispatch_rd=1, no side effects.
// - Stall (dispatch_rd=0, nothing changes) when:
//     - target queue full, or
//     - tag needed but FIFO empty, or
//     - branch/JALR source still pending.
// - Operand source: if RST pending, use the tag (valid=0). Exception: cdb_valid and cdb_tag==tag bypass cdb_data (valid=1). Otherwise use RF data (valid=1).
// - On dispatch with rd:
//     - pop a tag -> rd_tag.
//     - if rd!=0, set RST[rd]={1,tag}.
//     - rd==x0 still takes a tag; RST untouched.
// - CDB (cdb_valid), same edge:
//     - every RST entry pending with matching tag: RF<=data, pending<=0.
//     - tag pushed back to FIFO.
//     - a same-cycle dispatch to that reg wins (new tag kept pending).
//     - simultaneous push/pop both take effect.
// - BRANCH:
//     - wait until both sources are ready (CDB bypass allowed).
//     - evaluate funct3 (BEQ/BNE/BLT/BGE/BLTU/BGEU).
//     - dispatch_rd=1; taken -> jump_branch_valid=1, add=pc+B-imm; else no redirect.
// - JAL: dispatch_rd=1, jump_branch_valid=1, add=pc+J-imm. RF[rd]<=pc+4, RST[rd] cleared; no tag.
// - JALR: wait for rs1; add=(rs1+I-imm)&~1. rd is written as for JAL.
// - No speculation; the instruction after a redirect is discarded by fetch.
// STRUCTURE
// - Package disp_pkg: opcode localparams, tag_t, imm-extract functions, queue-select enum.
// - Sub-module tag_free_fifo (64x6, preload on reset, push/pop same cycle).
// - cdb_bus / queue_cmn_bus are interfaces. dispatch_unit_smart_bmf models queues and CDB in the bench.
// TESTING
// - Reset, then PC 0x400000 addi x4,x0,10 (00a00213) -> int_queue_en=1, disp_imm=1, imm=10, rs1_valid=1 data 0, rd_tag=0.
// - add x7,x5,x4 (004283b3) after addi x5/x4 dispatch, before CDB -> rs1_tag=1, rs2_tag=0, both valid=0.
// - beq x4,x5,16 (00520863) at 0x400010 -> stalls until CDB returns 10/11, then dispatch_rd=1, no redirect.
// - beq x7,x6,12 (00638663) at 0x400014, x7=x6=21 -> jump_branch_valid=1, add=0x400020.
// - mul x8,x4,x5 (02520433) -> mult_queue_en; with mult_full=1 -> dispatch_rd=0, held.
// - sw (fc452a23) -> mem_queue_en, no tag popped. jal x1,12 (00c000ef) at 0x400034 -> add=0x400040, x1=0x400038.

Source files
------------

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_pkg
// Purpose  : RV32IM opcodes, tag type, immediate extractors and queue select
// Revision : 1.0
// ============================================================================
package disp_pkg;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef logic [5:0] tag_t;

    typedef enum logic [2:0] {Q_NONE, Q_INT, Q_MULT, Q_DIV, Q_MEM} queue_sel_e;

    function automatic logic [31:0] imm_i(input logic [31:0] ic);
        return {{20{ic[31]}}, ic[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ic);
        return {{20{ic[31]}}, ic[31:25], ic[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ic);
        return {{19{ic[31]}}, ic[31], ic[7], ic[30:25], ic[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ic);
        return {ic[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ic);
        return {{11{ic[31]}}, ic[31], ic[19:12], ic[20], ic[30:21], 1'b0};
    endfunction
endpackage
`default_nettype wire

// File: rtl/disp_if.sv
`default_nettype none
// ============================================================================
// Module   : cdb_bus / queue_cmn_bus
// Purpose  : Common data bus and the shared issue-queue write bus
// Revision : 1.0
// ============================================================================
interface cdb_bus #(parameter int TAG_W = 6, parameter int XLEN = 32);
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;

    modport disp (input cdb_valid, cdb_tag, cdb_data);
    modport src  (output cdb_valid, cdb_tag, cdb_data);
endinterface

interface queue_cmn_bus #(parameter int TAG_W = 6, parameter int XLEN = 32);
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs1_valid;
    logic             rs2_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0]  imm;
    logic [2:0]       funct3;
    logic             int_full;
    logic             mult_full;
    logic             div_full;
    logic             mem_full;

    modport disp  (output rs1_data, rs2_data, rs1_tag, rs2_tag, rs1_valid, rs2_valid,
                          rd_tag, imm, funct3,
                   input  int_full, mult_full, div_full, mem_full);
    modport queue (input  rs1_data, rs2_data, rs1_tag, rs2_tag, rs1_valid, rs2_valid,
                          rd_tag, imm, funct3,
                   output int_full, mult_full, div_full, mem_full);
endinterface
`default_nettype wire

// File: rtl/tag_free_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tag_free_fifo
// Purpose  : Free result-tag list, preloaded with every tag on reset
// Revision : 1.0
// ============================================================================
module tag_free_fifo #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head_tag,
    output logic             empty
);
    localparam int DEPTH = 1 << TAG_W;

    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [TAG_W-1:0] r_rd;
    logic [TAG_W-1:0] r_wr;
    logic [TAG_W:0]   r_count;
    logic             w_pop;
    logic             w_push;

    assign head_tag = r_mem[r_rd];
    assign empty    = (r_count == '0);
    assign w_pop    = pop & ~empty;
    // A push into a full list is only legal when a pop frees a slot that cycle
    assign w_push   = push & ((r_count != (TAG_W+1)'(DEPTH)) | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= TAG_W'(i);
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= (TAG_W+1)'(DEPTH);
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= push_tag;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + {{TAG_W{1'b0}}, w_push} - {{TAG_W{1'b0}}, w_pop};
        end
    end
endmodule
`default_nettype wire

// File: rtl/superscalar_dispatch_unit.sv
`default_nettype none
// ============================================================================
// Module   : superscalar_dispatch_unit
// Purpose  : In-order RV32IM Tomasulo dispatcher with in-house branch resolve
// Revision : 1.0
// ============================================================================
module superscalar_dispatch_unit
    import disp_pkg::*;
#(
    parameter int TAG_W = 6,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     ifq_icode,
    input  logic [XLEN-1:0] ifq_pc,
    input  logic            ifq_empty,
    output logic            dispatch_rd,
    output logic [XLEN-1:0] jump_branch_add,
    output logic            jump_branch_valid,
    cdb_bus.disp            cdb,
    queue_cmn_bus.disp      queue_bus,
    output logic            int_queue_en,
    output logic            disp_imm,
    output logic [XLEN-1:0] disp_pc,
    output logic [6:0]      opcode,
    output logic [6:0]      funct7,
    output logic            mult_queue_en,
    output logic            div_queue_en,
    output logic            mem_queue_en
);
    logic [XLEN-1:0]  r_rf  [32];
    logic [TAG_W-1:0] r_tag [32];
    logic [31:0]      r_pend;

    logic [TAG_W-1:0] w_free_tag;
    logic             w_fifo_empty, w_pop, w_valid, w_go, w_link, w_full, w_stall, w_taken;
    logic [6:0]       w_op;
    logic [4:0]       w_rs1, w_rs2, w_rd;
    logic [2:0]       w_f3;
    logic [XLEN-1:0]  w_op1, w_op2, w_imm, w_target;
    logic             w_op1_ok, w_op2_ok;
    logic [TAG_W-1:0] w_op1_tag, w_op2_tag;
    queue_sel_e       w_qsel;
    logic             w_need_tag, w_use_imm, w_is_br, w_is_jal, w_is_jalr;

    assign w_valid = ~rst & ~ifq_empty;
    assign w_op    = ifq_icode[6:0];
    assign w_rd    = ifq_icode[11:7];
    assign w_f3    = ifq_icode[14:12];
    assign w_rs1   = ifq_icode[19:15];
    assign w_rs2   = ifq_icode[24:20];

    // A pending source whose tag is on the CDB this cycle is taken as ready
    always_comb begin
        w_op1 = r_rf[w_rs1]; w_op1_ok = 1'b1; w_op1_tag = '0;
        if (r_pend[w_rs1]) begin
            w_op1_tag = r_tag[w_rs1];
            if (cdb.cdb_valid && cdb.cdb_tag == r_tag[w_rs1]) w_op1 = cdb.cdb_data;
            else begin w_op1 = '0; w_op1_ok = 1'b0; end
        end
        w_op2 = r_rf[w_rs2]; w_op2_ok = 1'b1; w_op2_tag = '0;
        if (r_pend[w_rs2]) begin
            w_op2_tag = r_tag[w_rs2];
            if (cdb.cdb_valid && cdb.cdb_tag == r_tag[w_rs2]) w_op2 = cdb.cdb_data;
            else begin w_op2 = '0; w_op2_ok = 1'b0; end
        end
    end

    always_comb begin
        w_qsel = Q_NONE; w_need_tag = 1'b0; w_use_imm = 1'b0; w_imm = '0;
        w_is_br = 1'b0; w_is_jal = 1'b0; w_is_jalr = 1'b0;
        case (w_op)
            OP_OP: begin
                w_qsel     = (ifq_icode[31:25] == F7_MULDIV) ? (w_f3[2] ? Q_DIV : Q_MULT) : Q_INT;
                w_need_tag = 1'b1;
            end
            OP_IMM:           begin w_qsel = Q_INT; w_need_tag = 1'b1; w_use_imm = 1'b1; w_imm = imm_i(ifq_icode); end
            OP_LUI, OP_AUIPC: begin w_qsel = Q_INT; w_need_tag = 1'b1; w_use_imm = 1'b1; w_imm = imm_u(ifq_icode); end
            OP_LOAD:          begin w_qsel = Q_MEM; w_need_tag = 1'b1; w_imm = imm_i(ifq_icode); end
            OP_STORE:         begin w_qsel = Q_MEM; w_imm = imm_s(ifq_icode); end
            OP_BRANCH:        begin w_is_br = 1'b1;   w_imm = imm_b(ifq_icode); end
            OP_JAL:           begin w_is_jal = 1'b1;  w_imm = imm_j(ifq_icode); end
            OP_JALR:          begin w_is_jalr = 1'b1; w_imm = imm_i(ifq_icode); end
            default: ;
        endcase
    end

    always_comb begin
        case (w_qsel)
            Q_INT:   w_full = queue_bus.int_full;
            Q_MULT:  w_full = queue_bus.mult_full;
            Q_DIV:   w_full = queue_bus.div_full;
            Q_MEM:   w_full = queue_bus.mem_full;
            default: w_full = 1'b0;
        endcase
        case (w_f3)
            3'b000:  w_taken = (w_op1 == w_op2);
            3'b001:  w_taken = (w_op1 != w_op2);
            3'b100:  w_taken = ($signed(w_op1) <  $signed(w_op2));
            3'b101:  w_taken = ($signed(w_op1) >= $signed(w_op2));
            3'b110:  w_taken = (w_op1 <  w_op2);
            3'b111:  w_taken = (w_op1 >= w_op2);
            default: w_taken = 1'b0;
        endcase
        w_target = w_is_jalr ? ((w_op1 + w_imm) & ~XLEN'(1)) : (ifq_pc + w_imm);
    end

    assign w_stall = w_full | (w_need_tag & w_fifo_empty)
                   | (w_is_br & ~(w_op1_ok & w_op2_ok)) | (w_is_jalr & ~w_op1_ok);
    assign w_go    = w_valid & ~w_stall;
    assign w_pop   = w_go & w_need_tag;
    assign w_link  = w_go & (w_is_jal | w_is_jalr);

    assign dispatch_rd       = w_go;
    assign jump_branch_valid = w_go & (w_is_jal | w_is_jalr | (w_is_br & w_taken));
    assign jump_branch_add   = jump_branch_valid ? w_target : '0;
    assign int_queue_en      = w_go & (w_qsel == Q_INT);
    assign mult_queue_en     = w_go & (w_qsel == Q_MULT);
    assign div_queue_en      = w_go & (w_qsel == Q_DIV);
    assign mem_queue_en      = w_go & (w_qsel == Q_MEM);
    assign disp_imm          = w_valid & w_use_imm;
    assign disp_pc           = w_valid ? ifq_pc : '0;
    assign opcode            = w_valid ? w_op : '0;
    assign funct7            = w_valid ? ifq_icode[31:25] : '0;

    assign queue_bus.rs1_data  = w_valid ? w_op1 : '0;
    assign queue_bus.rs2_data  = w_valid ? w_op2 : '0;
    assign queue_bus.rs1_tag   = w_valid ? w_op1_tag : '0;
    assign queue_bus.rs2_tag   = w_valid ? w_op2_tag : '0;
    assign queue_bus.rs1_valid = w_valid & w_op1_ok;
    assign queue_bus.rs2_valid = w_valid & w_op2_ok;
    assign queue_bus.rd_tag    = (w_valid & w_need_tag) ? w_free_tag : '0;
    assign queue_bus.imm       = w_valid ? w_imm : '0;
    assign queue_bus.funct3    = w_valid ? w_f3 : '0;

    tag_free_fifo #(.TAG_W(TAG_W)) u_free_tags (
        .clk      (clk),
        .rst      (rst),
        .push     (cdb.cdb_valid),
        .push_tag (cdb.cdb_tag),
        .pop      (w_pop),
        .head_tag (w_free_tag),
        .empty    (w_fifo_empty)
    );

    // x0 is never written and never marked pending, so it always reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            for (int i = 0; i < 32; i++) begin
                r_rf[i]  <= '0;
                r_tag[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (cdb.cdb_valid && r_pend[i] && r_tag[i] == cdb.cdb_tag) begin
                    r_rf[i]   <= cdb.cdb_data;
                    r_pend[i] <= 1'b0;
                end
                // A same-cycle dispatch to this register overrides the CDB clear
                if (w_rd == 5'(i)) begin
                    if (w_pop) begin
                        r_pend[i] <= 1'b1;
                        r_tag[i]  <= w_free_tag;
                    end else if (w_link) begin
                        r_rf[i]   <= ifq_pc + XLEN'(4);
                        r_pend[i] <= 1'b0;
                    end
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_superscalar_dispatch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_superscalar_dispatch_unit
// Purpose  : Directed self-checking bench for superscalar_dispatch_unit
// Revision : 1.0
// ============================================================================
module tb_superscalar_dispatch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifq_icode, ifq_pc;
    logic        ifq_empty;
    logic        dispatch_rd, jump_branch_valid, int_queue_en, disp_imm;
    logic        mult_queue_en, div_queue_en, mem_queue_en;
    logic [31:0] jump_branch_add, disp_pc;
    logic [6:0]  opcode, funct7;
    int          vectors = 0;
    int          errors  = 0;

    cdb_bus       #(.TAG_W(6), .XLEN(32)) cdb_if ();
    queue_cmn_bus #(.TAG_W(6), .XLEN(32)) q_if ();

    superscalar_dispatch_unit #(.TAG_W(6), .XLEN(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .ifq_icode         (ifq_icode),
        .ifq_pc            (ifq_pc),
        .ifq_empty         (ifq_empty),
        .dispatch_rd       (dispatch_rd),
        .jump_branch_add   (jump_branch_add),
        .jump_branch_valid (jump_branch_valid),
        .cdb               (cdb_if),
        .queue_bus         (q_if),
        .int_queue_en      (int_queue_en),
        .disp_imm          (disp_imm),
        .disp_pc           (disp_pc),
        .opcode            (opcode),
        .funct7            (funct7),
        .mult_queue_en     (mult_queue_en),
        .div_queue_en      (div_queue_en),
        .mem_queue_en      (mem_queue_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] ic, input logic [31:0] pc);
        ifq_icode = ic; ifq_pc = pc; ifq_empty = 1'b0;
        #1;
    endtask

    task automatic cdb_set(input logic v, input logic [5:0] tag, input logic [31:0] data);
        cdb_if.cdb_valid = v; cdb_if.cdb_tag = tag; cdb_if.cdb_data = data;
        #1;
    endtask

    initial begin
        rst = 1'b1; ifq_empty = 1'b0; ifq_icode = 32'h00a00213; ifq_pc = 32'h0040_0000;
        cdb_if.cdb_valid = 1'b0; cdb_if.cdb_tag = '0; cdb_if.cdb_data = '0;
        q_if.int_full = 1'b0; q_if.mult_full = 1'b0; q_if.div_full = 1'b0; q_if.mem_full = 1'b0;
        tick(); tick();
        chk("rst_dispatch_rd", 32'(dispatch_rd), 32'd0);
        chk("rst_int_en",      32'(int_queue_en), 32'd0);
        chk("rst_opcode",      32'(opcode), 32'd0);
        rst = 1'b0;

        put(32'h00a00213, 32'h0040_0000);          // addi x4,x0,10
        chk("addi_dispatch", 32'(dispatch_rd), 32'd1);
        chk("addi_int_en",   32'(int_queue_en), 32'd1);
        chk("addi_disp_imm", 32'(disp_imm), 32'd1);
        chk("addi_imm",      q_if.imm, 32'd10);
        chk("addi_rs1_v",    32'(q_if.rs1_valid), 32'd1);
        chk("addi_rs1_d",    q_if.rs1_data, 32'd0);
        chk("addi_rd_tag",   32'(q_if.rd_tag), 32'd0);
        chk("addi_pc",       disp_pc, 32'h0040_0000);
        chk("addi_opcode",   32'(opcode), 32'h13);
        tick();
        put(32'h00b00293, 32'h0040_0004);          // addi x5,x0,11
        chk("addi5_rd_tag", 32'(q_if.rd_tag), 32'd1);
        tick();
        put(32'h004283b3, 32'h0040_0008);          // add x7,x5,x4
        chk("add_rs1_tag", 32'(q_if.rs1_tag), 32'd1);
        chk("add_rs2_tag", 32'(q_if.rs2_tag), 32'd0);
        chk("add_rs1_v",   32'(q_if.rs1_valid), 32'd0);
        chk("add_rs2_v",   32'(q_if.rs2_valid), 32'd0);
        chk("add_disp_imm", 32'(disp_imm), 32'd0);
        chk("add_rd_tag",  32'(q_if.rd_tag), 32'd2);
        tick();
        put(32'h01500313, 32'h0040_000c);          // addi x6,x0,21
        chk("addi6_rd_tag", 32'(q_if.rd_tag), 32'd3);
        tick();

        put(32'h00520863, 32'h0040_0010);          // beq x4,x5,16
        chk("beq1_stall", 32'(dispatch_rd), 32'd0);
        cdb_set(1'b1, 6'd0, 32'd10);
        chk("beq1_half_ready", 32'(dispatch_rd), 32'd0);
        tick();
        cdb_set(1'b1, 6'd1, 32'd11);
        chk("beq1_go",       32'(dispatch_rd), 32'd1);
        chk("beq1_no_jump",  32'(jump_branch_valid), 32'd0);
        tick();
        cdb_set(1'b0, 6'd0, 32'd0);

        put(32'h00638663, 32'h0040_0014);          // beq x7,x6,12
        chk("beq2_stall", 32'(dispatch_rd), 32'd0);
        cdb_set(1'b1, 6'd2, 32'd21);
        chk("beq2_half_ready", 32'(dispatch_rd), 32'd0);
        tick();
        cdb_set(1'b1, 6'd3, 32'd21);
        chk("beq2_go",    32'(dispatch_rd), 32'd1);
        chk("beq2_jump",  32'(jump_branch_valid), 32'd1);
        chk("beq2_add",   jump_branch_add, 32'h0040_0020);
        tick();
        cdb_set(1'b0, 6'd0, 32'd0);

        q_if.mult_full = 1'b1;
        put(32'h02520433, 32'h0040_0020);          // mul x8,x4,x5
        chk("mul_full_stall", 32'(dispatch_rd), 32'd0);
        chk("mul_full_en",    32'(mult_queue_en), 32'd0);
        tick();
        q_if.mult_full = 1'b0; #1;
        chk("mul_en",     32'(mult_queue_en), 32'd1);
        chk("mul_int_en", 32'(int_queue_en), 32'd0);
        chk("mul_rs1",    q_if.rs1_data, 32'd10);
        chk("mul_rs2",    q_if.rs2_data, 32'd11);
        chk("mul_rd_tag", 32'(q_if.rd_tag), 32'd4);
        tick();
        put(32'h025244b3, 32'h0040_0024);          // div x9,x4,x5
        chk("div_en",     32'(div_queue_en), 32'd1);
        chk("div_funct3", 32'(q_if.funct3), 32'd4);
        chk("div_rd_tag", 32'(q_if.rd_tag), 32'd5);
        tick();

        put(32'hfc452a23, 32'h0040_0028);          // sw x4,-44(x10)
        chk("sw_en",  32'(mem_queue_en), 32'd1);
        chk("sw_imm", q_if.imm, 32'hffff_ffd4);
        chk("sw_rs2", q_if.rs2_data, 32'd10);
        tick();
        q_if.mem_full = 1'b1;
        put(32'h00802583, 32'h0040_002c);          // lw x11,8(x0)
        chk("lw_full_stall", 32'(dispatch_rd), 32'd0);
        q_if.mem_full = 1'b0; #1;
        chk("lw_en",     32'(mem_queue_en), 32'd1);
        chk("lw_imm",    q_if.imm, 32'd8);
        chk("lw_rd_tag", 32'(q_if.rd_tag), 32'd6);
        tick();

        put(32'h00c000ef, 32'h0040_0034);          // jal x1,12
        chk("jal_go",   32'(dispatch_rd), 32'd1);
        chk("jal_jump", 32'(jump_branch_valid), 32'd1);
        chk("jal_add",  jump_branch_add, 32'h0040_0040);
        chk("jal_no_q", 32'(int_queue_en), 32'd0);
        tick();
        put(32'h00008113, 32'h0040_0040);          // addi x2,x1,0
        chk("link_rs1_v", 32'(q_if.rs1_valid), 32'd1);
        chk("link_rs1_d", q_if.rs1_data, 32'h0040_0038);
        chk("link_rd_tag", 32'(q_if.rd_tag), 32'd7);
        tick();

        put(32'h00440067, 32'h0040_0044);          // jalr x0,4(x8)
        chk("jalr_stall", 32'(dispatch_rd), 32'd0);
        cdb_set(1'b1, 6'd4, 32'h0040_1001);
        chk("jalr_jump", 32'(jump_branch_valid), 32'd1);
        chk("jalr_add",  jump_branch_add, 32'h0040_1004);
        tick();
        cdb_set(1'b0, 6'd0, 32'd0);

        q_if.int_full = 1'b1;
        put(32'h00500013, 32'h0040_1004);          // addi x0,x0,5
        chk("int_full_stall", 32'(dispatch_rd), 32'd0);
        q_if.int_full = 1'b0; #1;
        chk("x0_rd_tag", 32'(q_if.rd_tag), 32'd8);
        tick();
        put(32'h00000633, 32'h0040_1008);          // add x12,x0,x0
        chk("x0_rs1_v",   32'(q_if.rs1_valid), 32'd1);
        chk("x0_rs1_d",   q_if.rs1_data, 32'd0);
        chk("x12_rd_tag", 32'(q_if.rd_tag), 32'd9);
        tick();
        put(32'h0000000f, 32'h0040_100c);          // fence: treated as NOP
        chk("nop_go",   32'(dispatch_rd), 32'd1);
        chk("nop_qens", {28'd0, int_queue_en, mult_queue_en, div_queue_en, mem_queue_en}, 32'd0);
        tick();
        ifq_empty = 1'b1; #1;
        chk("empty_dispatch", 32'(dispatch_rd), 32'd0);
        chk("empty_opcode",   32'(opcode), 32'd0);

        // Drain the remaining 59 free tags: 10..63 then the returned 0..4
        for (int k = 0; k < 59; k++) begin
            put(32'h00500013, 32'h0040_2000);
            chk("drain_go", 32'(dispatch_rd), 32'd1);
            chk("drain_tag", 32'(q_if.rd_tag), (k < 54) ? 32'(10 + k) : 32'(k - 54));
            tick();
        end
        chk("fifo_empty_stall", 32'(dispatch_rd), 32'd0);
        put(32'hfc452a23, 32'h0040_2004);          // stores need no tag
        chk("empty_sw_go", 32'(mem_queue_en), 32'd1);
        tick();
        put(32'h000606b3, 32'h0040_2008);          // add x13,x12,x0
        cdb_set(1'b1, 6'd9, 32'd7);
        chk("push_same_cycle_stall", 32'(dispatch_rd), 32'd0);
        tick();
        cdb_set(1'b0, 6'd0, 32'd0);
        chk("refill_go",  32'(dispatch_rd), 32'd1);
        chk("refill_tag", 32'(q_if.rd_tag), 32'd9);
        chk("x12_value",  q_if.rs1_data, 32'd7);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire
